bloom_mem_responder: RTL and testbench
======================================

// Module: bloom_mem_responder
// PURPOSE
//  On-chip memory responder for the Bloom-filter memory request interface (responder end of rd/raddr, wr/waddr/wdata,
//  ready, rdata/rdata_valid). Serves 512-bit line reads and writes from a block-RAM array, returns read data in order,
//  and zero-clears the array after reset or on request so the filter starts empty. Replaces external DDR for small filters/sim.
// PARAMETERS
//  DATA_WIDTH      512  line width, bits
//  ADDR_WIDTH      30   request address width; only low MEM_ADDR_BITS used, upper bits ignored
//  MEM_ADDR_BITS   10   log2(lines in array); depth = 2**MEM_ADDR_BITS
//  READ_LATENCY    2    array read pipeline stages (>=1)
//  RESP_FIFO_DEPTH 8    read-response FIFO entries (power of 2, >= READ_LATENCY)
//  RESP_PTR_BITS   4    log2(RESP_FIFO_DEPTH)+1
// PORTS
//  clk          in   1              clock
//  rstb         in   1              synchronous active-low reset
//  clear        in   1              pulse: re-zero entire array
//  rd           in   1              read request
//  raddr        in   ADDR_WIDTH     read line address
//  wr           in   1              write request
//  waddr        in   ADDR_WIDTH     write line address
//  wdata        in   DATA_WIDTH     write data
//  ready        out  1              requests accepted this cycle when high
//  rdata        out  DATA_WIDTH     read response data (FIFO head)
//  rdata_valid  out  1              rdata valid
//  rdata_ready  in   1              consumer takes rdata this cycle (tie 1 if no backpressure)
//  init_done    out  1              array cleared, serving requests
// BEHAVIOUR
//  - Reset (rstb=0 at posedge): ready=0, rdata_valid=0, rdata=0, init_done=0; FIFO, pipeline, counters emptied; in-flight
//    reads discarded; FSM -> CLEAR, clear address=0. Reset mid-operation identical.
//  - FSM: CLEAR: write 0 to line clr_addr, clr_addr++ each cycle; after line depth-1 -> SERVE (clear takes exactly
//    2**MEM_ADDR_BITS cycles, init_done=1 from next cycle). SERVE: clear=1 -> DRAIN. DRAIN: ready=0; when occupancy==0 ->
//    CLEAR (clr_addr=0, init_done=0). clear ignored in CLEAR/DRAIN.
//  - ready = (state==SERVE) & (occupancy < RESP_FIFO_DEPTH); combinational from registered state only, never from rd/wr.
//  - occupancy = reads in pipeline + FIFO entries; +1 per accepted read, -1 per pop (rdata_valid & rdata_ready), both same
//    cycle -> unchanged. Never exceeds RESP_FIFO_DEPTH, so FIFO never overflows.
//  - Acceptance: rd/wr with ready=0 are ignored (initiator holds). Write accepted -> array updated at that edge; consumes no credit.
//  - Ordering: read accepted in cycle t returns array contents including all writes accepted in cycles < t. rd and wr same cycle,
//    same line: read returns OLD data (read-first); different lines: independent.
//  - Latency: read accepted cycle t with empty FIFO and rdata_ready=1 -> rdata_valid=1 in cycle t+READ_LATENCY. Responses strictly
//    in request order; one response per accepted read; rdata holds while rdata_valid & ~rdata_ready.
//  - FIFO full and empty: push and pop same cycle allowed; pointers wrap modulo depth with extra MSB for full/empty.
//  - Address: line index = addr[MEM_ADDR_BITS-1:0]; aliasing of upper bits is intentional.
// TESTING
//  - Reset, then hold rstb=1 -> ready=0 for 1024 cycles, init_done/ready=1 at cycle 1025; read line 5 -> rdata=0.
//  - Write 0xA5.. to line 3 in cycle t, read line 3 in t+1 -> rdata_valid at t+3 with 0xA5..; same-cycle rd/wr line 3 -> old data.
//  - rdata_ready=0, issue 10 back-to-back reads -> 8 accepted, ready drops after 8th; release -> 8 responses in address order.
//  - Continuous reads with rdata_ready=1 -> one read accepted and one response every cycle, ready never drops.
//  - clear with 3 reads outstanding -> ready=0, 3 responses delivered, then 1024-cycle clear; prior writes read back as 0.
//  - rstb=0 for one cycle with 4 reads in flight -> no responses emerge; init repeats; raddr 0x400 aliases line 0.

Source files
------------

// File: rtl/bloom_mem_responder_if.sv
// Bloom-filter memory request/response bus between a request initiator (master)
// and a memory responder (slave).
interface bloom_mem_responder_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 30
) ();
    logic                  rd;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  rdata_ready;

    modport master (
        output rd, raddr, wr, waddr, wdata, rdata_ready,
        input  ready, rdata, rdata_valid
    );

    modport slave (
        input  rd, raddr, wr, waddr, wdata, rdata_ready,
        output ready, rdata, rdata_valid
    );
endinterface

// File: rtl/bloom_mem_responder.sv
// On-chip line memory for the Bloom filter: in-order read responses through a
// credit-limited pipeline + FIFO, and a full zero sweep after reset or on request.
module bloom_mem_responder #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 30,
    parameter int MEM_ADDR_BITS   = 10,
    parameter int READ_LATENCY    = 2,
    parameter int RESP_FIFO_DEPTH = 8,
    parameter int RESP_PTR_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 clear,
    bloom_mem_responder_if.slave bus,
    output logic                 init_done
);
    localparam int MEM_DEPTH     = 32'd1 << MEM_ADDR_BITS;
    localparam int FIFO_IDX_BITS = RESP_PTR_BITS - 1;

    localparam logic [RESP_PTR_BITS-1:0] FIFO_DEPTH_C = RESP_PTR_BITS'(RESP_FIFO_DEPTH);
    localparam logic [RESP_PTR_BITS-1:0] PTR_ZERO_C   = {RESP_PTR_BITS{1'b0}};
    localparam logic [RESP_PTR_BITS-1:0] PTR_STEP_C   = {{(RESP_PTR_BITS-1){1'b0}}, 1'b1};
    localparam logic [MEM_ADDR_BITS-1:0] CLR_ZERO_C   = {MEM_ADDR_BITS{1'b0}};
    localparam logic [MEM_ADDR_BITS-1:0] CLR_STEP_C   = {{(MEM_ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [MEM_ADDR_BITS-1:0] CLR_LAST_C   = {MEM_ADDR_BITS{1'b1}};
    localparam logic [DATA_WIDTH-1:0]    LINE_ZERO_C  = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_SERVE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                   state_r;
    logic [MEM_ADDR_BITS-1:0] clr_addr_r;
    logic                     init_done_r;
    logic [RESP_PTR_BITS-1:0] occ_r;

    logic [DATA_WIDTH-1:0]    mem_r       [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]    pipe_data_r [READ_LATENCY];
    logic [READ_LATENCY-1:0]  pipe_valid_r;
    logic [DATA_WIDTH-1:0]    fifo_mem_r  [RESP_FIFO_DEPTH];
    logic [RESP_PTR_BITS-1:0] fifo_wr_ptr_r;
    logic [RESP_PTR_BITS-1:0] fifo_rd_ptr_r;

    logic                     ready_s;
    logic                     rd_accept_s;
    logic                     wr_accept_s;
    logic                     mem_we_s;
    logic [MEM_ADDR_BITS-1:0] mem_waddr_s;
    logic [DATA_WIDTH-1:0]    mem_wdata_s;
    logic                     fifo_empty_s;
    logic                     pipe_out_valid_s;
    logic                     rdata_valid_s;
    logic [DATA_WIDTH-1:0]    head_s;
    logic                     pop_s;
    logic                     fifo_push_s;
    logic                     fifo_pop_s;
    logic [RESP_PTR_BITS-1:0] occ_inc_s;
    logic [RESP_PTR_BITS-1:0] occ_dec_s;
    logic                     unused_addr_s;

    // Acceptance, array write-port steering and response-path selection.
    always_comb begin
        ready_s          = 1'b0;
        mem_we_s         = 1'b0;
        mem_waddr_s      = CLR_ZERO_C;
        mem_wdata_s      = LINE_ZERO_C;
        head_s           = LINE_ZERO_C;

        if ((state_r == ST_SERVE) && (occ_r < FIFO_DEPTH_C)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end

        rd_accept_s = bus.rd & ready_s;
        wr_accept_s = bus.wr & ready_s;

        // The clear sweep owns the write port; requests cannot be accepted then.
        if (state_r == ST_CLEAR) begin
            mem_we_s    = rstb;
            mem_waddr_s = clr_addr_r;
            mem_wdata_s = LINE_ZERO_C;
        end else begin
            mem_we_s    = wr_accept_s & rstb;
            mem_waddr_s = bus.waddr[MEM_ADDR_BITS-1:0];
            mem_wdata_s = bus.wdata;
        end

        fifo_empty_s     = (fifo_wr_ptr_r == fifo_rd_ptr_r);
        pipe_out_valid_s = pipe_valid_r[READ_LATENCY-1];
        rdata_valid_s    = ~fifo_empty_s | pipe_out_valid_s;

        // An empty FIFO is bypassed so the pipeline output is presented directly.
        if (fifo_empty_s) begin
            head_s = pipe_data_r[READ_LATENCY-1];
        end else begin
            head_s = fifo_mem_r[fifo_rd_ptr_r[FIFO_IDX_BITS-1:0]];
        end

        pop_s       = rdata_valid_s & bus.rdata_ready;
        fifo_pop_s  = ~fifo_empty_s & bus.rdata_ready;
        fifo_push_s = pipe_out_valid_s & ~(fifo_empty_s & bus.rdata_ready);

        occ_inc_s = {{(RESP_PTR_BITS-1){1'b0}}, rd_accept_s};
        occ_dec_s = {{(RESP_PTR_BITS-1){1'b0}}, pop_s};
    end

    // Control FSM: zero sweep, serving, draining outstanding reads before re-clear.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_r     <= ST_CLEAR;
            clr_addr_r  <= CLR_ZERO_C;
            init_done_r <= 1'b0;
            occ_r       <= PTR_ZERO_C;
        end else begin
            occ_r <= occ_r + occ_inc_s - occ_dec_s;
            case (state_r)
                ST_CLEAR: begin
                    if (clr_addr_r == CLR_LAST_C) begin
                        state_r     <= ST_SERVE;
                        clr_addr_r  <= CLR_ZERO_C;
                        init_done_r <= 1'b1;
                    end else begin
                        clr_addr_r  <= clr_addr_r + CLR_STEP_C;
                    end
                end
                ST_SERVE: begin
                    if (clear) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_SERVE;
                    end
                end
                ST_DRAIN: begin
                    if (occ_r == PTR_ZERO_C) begin
                        state_r     <= ST_CLEAR;
                        clr_addr_r  <= CLR_ZERO_C;
                        init_done_r <= 1'b0;
                    end else begin
                        state_r     <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    clr_addr_r  <= CLR_ZERO_C;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Read-pipeline valid bits and FIFO pointers; reset discards in-flight reads.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            pipe_valid_r  <= {READ_LATENCY{1'b0}};
            fifo_wr_ptr_r <= PTR_ZERO_C;
            fifo_rd_ptr_r <= PTR_ZERO_C;
        end else begin
            pipe_valid_r[0] <= rd_accept_s;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_valid_r[k] <= pipe_valid_r[k-1];
            end
            if (fifo_push_s) begin
                fifo_wr_ptr_r <= fifo_wr_ptr_r + PTR_STEP_C;
            end else begin
                fifo_wr_ptr_r <= fifo_wr_ptr_r;
            end
            if (fifo_pop_s) begin
                fifo_rd_ptr_r <= fifo_rd_ptr_r + PTR_STEP_C;
            end else begin
                fifo_rd_ptr_r <= fifo_rd_ptr_r;
            end
        end
    end

    // Line array (read-first on same-line rd/wr), read data pipeline and FIFO storage.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
        pipe_data_r[0] <= mem_r[bus.raddr[MEM_ADDR_BITS-1:0]];
        for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_data_r[k] <= pipe_data_r[k-1];
        end
        if (fifo_push_s) begin
            fifo_mem_r[fifo_wr_ptr_r[FIFO_IDX_BITS-1:0]] <= pipe_data_r[READ_LATENCY-1];
        end
    end

    // Upper address bits alias onto the same lines by design.
    assign unused_addr_s   = ^{bus.raddr[ADDR_WIDTH-1:MEM_ADDR_BITS],
                               bus.waddr[ADDR_WIDTH-1:MEM_ADDR_BITS]};

    assign bus.ready       = ready_s;
    assign bus.rdata_valid = rdata_valid_s;
    assign bus.rdata       = rdata_valid_s ? head_s : LINE_ZERO_C;
    assign init_done       = init_done_r;

endmodule

// File: tb/tb_bloom_mem_responder.sv
// Bench for bloom_mem_responder: per-cycle comparison against a queue/array model,
// a directed vector table, and hand sequences for backpressure, clear and reset.
module tb_bloom_mem_responder;
    localparam int DW    = 512;
    localparam int AW    = 30;
    localparam int LINES = 1024;
    localparam int NV    = 11;

    logic clk;
    logic rstb;
    logic clear;
    logic init_done;

    bloom_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bloom_mem_responder dut (
        .clk       (clk),
        .rstb      (rstb),
        .clear     (clear),
        .bus       (bus),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int cyc;

    // Behavioural model: line contents, pending responses with their due cycle.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    resp_t         exp_q [$];
    logic [DW-1:0] mem_m [LINES];
    logic          m_init;
    logic          m_drain;
    int            clr_next;

    typedef struct {
        logic          rd;
        logic [AW-1:0] raddr;
        logic          wr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          exp_ready;
        logic          exp_valid;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pat(int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {16{w}};
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock: compare outputs against the model, advance the model, step the DUT.
    task automatic cycle();
        logic e_ready;
        logic e_valid;
        int   occ_before;
        e_ready = m_init && !m_drain && (exp_q.size() < 8);
        e_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        check("ready", DW'(bus.ready), DW'(e_ready));
        check("init_done", DW'(init_done), DW'(m_init));
        check("rdata_valid", DW'(bus.rdata_valid), DW'(e_valid));
        if (e_valid) check("rdata", bus.rdata, exp_q[0].data);
        if (!rstb) begin
            exp_q.delete();
            m_init   = 1'b0;
            m_drain  = 1'b0;
            clr_next = 0;
        end else begin
            occ_before = exp_q.size();
            if (e_valid && bus.rdata_ready) void'(exp_q.pop_front());
            if (bus.rd && e_ready) exp_q.push_back('{mem_m[bus.raddr[9:0]], cyc + 2});
            if (bus.wr && e_ready) mem_m[bus.waddr[9:0]] = bus.wdata;
            if (!m_init) begin
                mem_m[clr_next] = {DW{1'b0}};
                clr_next++;
                if (clr_next == LINES) m_init = 1'b1;
            end else if (!m_drain) begin
                if (clear) m_drain = 1'b1;
            end else if (occ_before == 0) begin
                m_drain  = 1'b0;
                m_init   = 1'b0;
                clr_next = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        bus.rd    = 1'b0;
        bus.wr    = 1'b0;
        bus.raddr = {AW{1'b0}};
        bus.waddr = {AW{1'b0}};
        bus.wdata = {DW{1'b0}};
        clear     = 1'b0;
    endtask

    task automatic write_one(logic [AW-1:0] a, logic [DW-1:0] d);
        bus.wr = 1'b1; bus.waddr = a; bus.wdata = d;
        cycle();
        bus.wr = 1'b0;
    endtask

    task automatic read_one(logic [AW-1:0] a, logic [DW-1:0] d, string name);
        int t;
        bus.rd = 1'b1; bus.raddr = a;
        cycle();
        bus.rd = 1'b0;
        t = 0;
        while (!bus.rdata_valid && t < 10) begin cycle(); t++; end
        check({name, "_valid"}, DW'(bus.rdata_valid), DW'(1'b1));
        check({name, "_data"}, bus.rdata, d);
        cycle();
    endtask

    task automatic set_vec(int i, logic rd, logic [AW-1:0] ra, logic wr, logic [AW-1:0] wa,
                           logic [DW-1:0] wd, logic ev, logic [DW-1:0] ed);
        vecs[i] = '{rd, ra, wr, wa, wd, 1'b1, ev, ed};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] z;
        logic [DW-1:0] pa5;
        logic [DW-1:0] p5a;
        int n, k, t, acc, drops, v;

        total = 0; bad = 0; cyc = 0;
        z   = {DW{1'b0}};
        pa5 = {64{8'hA5}};
        p5a = {64{8'h5A}};
        for (int i = 0; i < LINES; i++) mem_m[i] = {DW{1'b0}};
        exp_q.delete();
        m_init = 1'b0; m_drain = 1'b0; clr_next = 0;

        // Directed table: write/read latency, read-first on same line, aliasing.
        set_vec(0,  1'b0, 30'd0,     1'b1, 30'd3, pa5, 1'b0, z);
        set_vec(1,  1'b1, 30'd3,     1'b0, 30'd0, z,   1'b0, z);
        set_vec(2,  1'b0, 30'd0,     1'b0, 30'd0, z,   1'b0, z);
        set_vec(3,  1'b1, 30'd3,     1'b1, 30'd3, p5a, 1'b1, pa5);
        set_vec(4,  1'b0, 30'd0,     1'b0, 30'd0, z,   1'b0, z);
        set_vec(5,  1'b1, 30'd5,     1'b0, 30'd0, z,   1'b1, pa5);
        set_vec(6,  1'b0, 30'd0,     1'b0, 30'd0, z,   1'b0, z);
        set_vec(7,  1'b1, 30'h403,   1'b0, 30'd0, z,   1'b1, z);
        set_vec(8,  1'b0, 30'd0,     1'b0, 30'd0, z,   1'b0, z);
        set_vec(9,  1'b0, 30'd0,     1'b0, 30'd0, z,   1'b1, p5a);
        set_vec(10, 1'b0, 30'd0,     1'b0, 30'd0, z,   1'b0, z);

        idle();
        rstb = 1'b0;
        bus.rdata_ready = 1'b1;
        @(posedge clk);
        #1;
        rstb = 1'b1;

        check("reset_rdata", bus.rdata, z);
        check("reset_init_done", DW'(init_done), DW'(1'b0));
        n = 0;
        while (!bus.ready && n < 2000) begin cycle(); n++; end
        check("init_cycles", DW'(n), DW'(LINES));

        for (int i = 0; i < NV; i++) begin
            bus.rd = vecs[i].rd; bus.raddr = vecs[i].raddr;
            bus.wr = vecs[i].wr; bus.waddr = vecs[i].waddr; bus.wdata = vecs[i].wdata;
            check($sformatf("vec%0d_ready", i), DW'(bus.ready), DW'(vecs[i].exp_ready));
            check($sformatf("vec%0d_valid", i), DW'(bus.rdata_valid), DW'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
            cycle();
        end
        idle();

        // Backpressure: 10 back-to-back reads, only 8 credits.
        for (int i = 0; i < 10; i++) write_one(AW'(i), pat(i));
        bus.rdata_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            bus.rd = 1'b1; bus.raddr = AW'(i);
            if (bus.ready) acc++;
            cycle();
        end
        bus.rd = 1'b0;
        check("bp_accepted", DW'(acc), DW'(8));
        check("bp_ready_low", DW'(bus.ready), DW'(1'b0));
        bus.rdata_ready = 1'b1;
        k = 0; t = 0;
        while (k < 8 && t < 40) begin
            if (bus.rdata_valid) begin
                check($sformatf("bp_data%0d", k), bus.rdata, pat(k));
                k++;
            end
            cycle(); t++;
        end
        check("bp_responses", DW'(k), DW'(8));

        // Continuous reads with no backpressure.
        drops = 0; k = 0;
        for (int i = 0; i < 40; i++) begin
            bus.rd = 1'b1; bus.raddr = AW'($urandom_range(0, 9));
            if (!bus.ready) drops++;
            if (bus.rdata_valid) k++;
            cycle();
        end
        bus.rd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.rdata_valid) k++;
            cycle();
        end
        check("stream_drops", DW'(drops), DW'(0));
        check("stream_responses", DW'(k), DW'(40));

        // Clear with three reads outstanding.
        bus.rdata_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.rd = 1'b1; bus.raddr = AW'(i);
            cycle();
        end
        bus.rd = 1'b0;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drain_ready_low", DW'(bus.ready), DW'(1'b0));
            cycle();
        end
        bus.rdata_ready = 1'b1;
        k = 0; t = 0;
        while (k < 3 && t < 20) begin
            if (bus.rdata_valid) begin
                check($sformatf("drain_data%0d", k), bus.rdata, pat(k));
                k++;
            end
            cycle(); t++;
        end
        check("drain_responses", DW'(k), DW'(3));
        t = 0;
        while (init_done && t < 50) begin cycle(); t++; end
        n = 0;
        while (!init_done && n < 2000) begin cycle(); n++; end
        check("reclear_cycles", DW'(n), DW'(LINES));
        read_one(30'd3, z, "cleared_line3");

        // Reset with reads in flight.
        write_one(30'd0, pat(20));
        bus.rdata_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.rd = 1'b1; bus.raddr = AW'(i);
            cycle();
        end
        bus.rd = 1'b0;
        rstb = 1'b0;
        cycle();
        rstb = 1'b1;
        bus.rdata_ready = 1'b1;
        n = 0; v = 0;
        while (!bus.ready && n < 2000) begin
            if (bus.rdata_valid) v++;
            cycle(); n++;
        end
        check("rst_no_resp", DW'(v), DW'(0));
        check("rst_init_cycles", DW'(n), DW'(LINES));
        write_one(30'd0, pat(11));
        read_one(30'h400, pat(11), "alias_line0");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.rd          = ($urandom_range(0, 1) == 1);
            bus.raddr       = {20'($urandom), 10'($urandom_range(0, 15))};
            bus.wr          = ($urandom_range(0, 2) == 0);
            bus.waddr       = {20'($urandom), 10'($urandom_range(0, 15))};
            bus.wdata       = rand_line();
            bus.rdata_ready = ($urandom_range(0, 3) != 0);
            clear           = ($urandom_range(0, 299) == 0);
            cycle();
        end
        idle();
        bus.rdata_ready = 1'b1;
        n = 0;
        while ((exp_q.size() > 0 || !m_init || m_drain) && n < 3000) begin cycle(); n++; end
        for (int i = 0; i < 4; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
